// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the chunked ripple-carry add controller.
// State enum, chunk width and the chunk-count helper live here.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CHUNK_W = 4;

    function automatic int num_chunks(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/rca_seq_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module rca_seq_adder_ctrl_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
        assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[4];

endmodule

// File: rtl/rca_seq_adder_ctrl.sv
// Wide add built by stepping one shared RCA4 over WIDTH/4 chunks, LSB chunk first.
// Optional subtract mode and signed overflow flag are enabled by RCA_SEQ_SUBTRACT_EN.
module rca_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryInput,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOutput
`ifdef RCA_SEQ_SUBTRACT_EN
    ,
    input  logic             sub,
    output logic             overflow
`endif
);

    import rca_seq_pkg::*;

    localparam int N     = num_chunks(WIDTH);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] rca_s;
    logic               rca_co;

`ifdef RCA_SEQ_SUBTRACT_EN
    logic sub_q, sub_d;
    logic ovf_q, ovf_d;
`endif

    assign a_chunk = a_q[idx_q*CHUNK_W +: CHUNK_W];

    // Subtraction feeds the inverted B chunk; the +1 comes in through the carry reg.
`ifdef RCA_SEQ_SUBTRACT_EN
    assign b_chunk = b_q[idx_q*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub_q}};
`else
    assign b_chunk = b_q[idx_q*CHUNK_W +: CHUNK_W];
`endif

    rca_seq_adder_ctrl_rca4 u_rca4 (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .s    (rca_s),
        .cout (rca_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef RCA_SEQ_SUBTRACT_EN
        sub_d   = sub_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef RCA_SEQ_SUBTRACT_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : carryInput;
`else
                    carry_d = carryInput;
`endif
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK_W +: CHUNK_W] = rca_s;
                carry_d = rca_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = rca_co;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef RCA_SEQ_SUBTRACT_EN
                    // Signed overflow: operands agree in sign but the result does not.
                    ovf_d = (a_chunk[CHUNK_W-1] == b_chunk[CHUNK_W-1]) &&
                            (rca_s[CHUNK_W-1] != a_chunk[CHUNK_W-1]);
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RCA_SEQ_SUBTRACT_EN
            sub_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef RCA_SEQ_SUBTRACT_EN
            sub_q   <= sub_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign carryOutput = cout_q;
`ifdef RCA_SEQ_SUBTRACT_EN
    assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Self-checking bench for rca_seq_adder_ctrl (WIDTH=16): directed cases plus random adds
// against a plain-arithmetic reference; subtract cases run when RCA_SEQ_SUBTRACT_EN is set.
module tb_rca_seq_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RCA_SEQ_SUBTRACT_EN
    logic         sub_in;
    logic         overflow;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    rca_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a_in),
        .b           (b_in),
        .carryInput  (cin),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .carryOutput (cout)
`ifdef RCA_SEQ_SUBTRACT_EN
        ,
        .sub         (sub_in),
        .overflow    (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: reference result from plain arithmetic, then latency/handshake checks.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic tsub, input bit scramble, input bit poke);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        logic         exp_ovf;
        int           k;
        if (tsub) full = {1'b0, ta} + {1'b0, ~tb_v} + 17'd1;
        else      full = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
        exp_sum = full[W-1:0];
        exp_co  = full[W];
        exp_ovf = (ta[W-1] != tb_v[W-1]) && (exp_sum[W-1] != ta[W-1]);

        @(negedge clk);
        a_in = ta; b_in = tb_v; cin = tc; start = 1'b1;
`ifdef RCA_SEQ_SUBTRACT_EN
        sub_in = tsub;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (k = 1; k <= N + 2; k++) begin
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
`ifdef RCA_SEQ_SUBTRACT_EN
                sub_in = 1'($urandom);
`endif
            end
            if (poke) begin
                start = 1'b1; a_in = 16'h0001; b_in = 16'h0001;
            end
            @(posedge clk); #1;
            if (done) break;
            check("busy_during_run", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        check("done_latency", k, N);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("sum", {16'd0, sum}, {16'd0, exp_sum});
        check("carryOutput", {31'd0, cout}, {31'd0, exp_co});
`ifdef RCA_SEQ_SUBTRACT_EN
        if (tsub) check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`endif
        $display("[TB] op a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d (exp %04h/%0d) ovf_exp=%0d",
                 ta, tb_v, tc, tsub, sum, cout, exp_sum, exp_co, exp_ovf);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("sum_held", {16'd0, sum}, {16'd0, exp_sum});
        @(posedge clk); #1;
        check("no_second_done", {31'd0, done}, 32'd0);
        check("cout_held", {31'd0, cout}, {31'd0, exp_co});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUBTRACT_EN
        sub_in = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle must abort with no done pulse.
        @(negedge clk);
        a_in = 16'hABCD; b_in = 16'h1234; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        $display("[TB] reset mid-run: sum=%04h cout=%0d busy=%0d done=%0d", sum, cout, busy, done);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(16'h7A5C, 16'h3C9E, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));

`ifdef RCA_SEQ_SUBTRACT_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
